// File: rtl/led_pio_ctrl.sv
// Avalon-MM LED PIO with DATA/OUTSET/OUTCLEAR registers and an optional blink overlay.
// Define LED_PIO_CTRL_BLINK_EN to build BLINK_MASK, BLINK_PERIOD, STATUS and the blink counter.
module led_pio_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter logic [31:0] RESET_VALUE  = 32'h1,
    parameter int unsigned PERIOD_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    typedef enum logic [2:0] {
        ADDR_DATA   = 3'd0,
        ADDR_RSVD1  = 3'd1,
        ADDR_OUTSET = 3'd2,
        ADDR_OUTCLR = 3'd3,
        ADDR_MASK   = 3'd4,
        ADDR_PERIOD = 3'd5,
        ADDR_STATUS = 3'd6,
        ADDR_RSVD7  = 3'd7
    } reg_addr_e;

    localparam logic [DATA_WIDTH-1:0] DATA_RST = RESET_VALUE[DATA_WIDTH-1:0];

    logic                  wr;
    logic [DATA_WIDTH-1:0] wd_data;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd_data   = writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign out_port  = out_q;

    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (address)
                ADDR_DATA:   data_d = wd_data;
                ADDR_OUTSET: data_d = data_q | wd_data;
                ADDR_OUTCLR: data_d = data_q & ~wd_data;
                default:     ;
            endcase
        end
    end

`ifdef LED_PIO_CTRL_BLINK_EN
    logic [DATA_WIDTH-1:0]   mask_q, mask_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic                    phase_q, phase_d;

    always_comb begin
        mask_d   = mask_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period_q - PERIOD_WIDTH'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + PERIOD_WIDTH'(1);
        end
        if (wr && address == ADDR_MASK) begin
            mask_d = wd_data;
        end
        // A period write restarts the blink even if the value is unchanged.
        if (wr && address == ADDR_PERIOD) begin
            period_d = writedata[PERIOD_WIDTH-1:0];
            cnt_d    = '0;
            phase_d  = 1'b0;
        end
        out_d = data_d ^ (mask_d & {DATA_WIDTH{phase_d}});
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[DATA_WIDTH-1:0]   = data_q;
            ADDR_MASK:   readdata[DATA_WIDTH-1:0]   = mask_q;
            ADDR_PERIOD: readdata[PERIOD_WIDTH-1:0] = period_q;
            ADDR_STATUS: readdata[0]                = phase_q;
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q   <= DATA_RST;
            out_q    <= DATA_RST;
            mask_q   <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else begin
            data_q   <= data_d;
            out_q    <= out_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end
`else
    assign out_d = data_d;

    always_comb begin
        readdata = '0;
        if (address == ADDR_DATA) begin
            readdata[DATA_WIDTH-1:0] = data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= DATA_RST;
            out_q  <= DATA_RST;
        end else begin
            data_q <= data_d;
            out_q  <= out_d;
        end
    end
`endif

endmodule

// File: doc/led_pio_ctrl.md
LED_PIO_CTRL -- requirements
Module: led_pio_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of LED output bits; legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 1: DATA register value after reset, truncated to DATA_WIDTH.
REQ-003 Parameter PERIOD_WIDTH, default 24: width of the blink half-period register and counter; legal range 1..32.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 address  input  3  Avalon-MM slave word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-009 writedata  input  32  write data; bits above the register width are ignored.
REQ-010 readdata  output  32  read data, combinational from address; unused upper bits read 0.
REQ-011 out_port  output  DATA_WIDTH  LED drive.

Function
REQ-012 The register map SHALL be: 0 DATA (RW); 1 reserved (reads 0); 2 OUTSET (write-only, reads 0); 3 OUTCLEAR (write-only, reads 0); 4 BLINK_MASK (RW, DATA_WIDTH bits); 5 BLINK_PERIOD (RW, PERIOD_WIDTH bits); 6 STATUS (RO: bit0 = phase); 7 reserved (reads 0).
REQ-013 A write to DATA SHALL load writedata[DATA_WIDTH-1:0] on the next clock edge.
REQ-014 A write to OUTSET SHALL OR writedata into DATA; a write to OUTCLEAR SHALL AND DATA with the inverse of writedata; zero bits leave DATA bits unchanged.
REQ-015 Writes to reserved or read-only addresses SHALL have no effect.
REQ-016 Reads SHALL have zero wait states and zero latency; readdata SHALL reflect register contents combinationally, independent of chipselect.
REQ-017 A free-running counter cnt SHALL increment every cycle while BLINK_PERIOD != 0; when cnt equals BLINK_PERIOD-1, cnt SHALL return to 0 and phase SHALL toggle on the same edge.
REQ-018 When BLINK_PERIOD = 0, cnt and phase SHALL be held at 0.
REQ-019 A write to BLINK_PERIOD SHALL clear cnt and phase on the same edge that loads the new value, including a write of the currently held value.
REQ-020 out_port SHALL equal DATA XOR (BLINK_MASK AND replicate(phase)); it SHALL be registered-only logic with no combinational path from writedata.
REQ-021 The blink half-period SHALL be exactly BLINK_PERIOD clock cycles; BLINK_PERIOD=1 SHALL toggle phase every cycle.
REQ-022 Counter wrap SHALL be defined for the maximum value 2^PERIOD_WIDTH-1 with no overflow beyond that value.
REQ-023 A DATA/OUTSET/OUTCLEAR write on the same edge as a phase toggle SHALL apply both; out_port SHALL reflect the new DATA and the new phase in the following cycle.

Reset
REQ-024 While reset_n=0 at a clock edge: DATA = RESET_VALUE, BLINK_MASK = 0, BLINK_PERIOD = 0, cnt = 0, phase = 0.
REQ-025 Reset SHALL override any simultaneous write, and SHALL abort a blink mid-period with no residual phase.
REQ-026 After reset, out_port SHALL equal RESET_VALUE[DATA_WIDTH-1:0].

Configuration
REQ-027 Macro LED_PIO_CTRL_BLINK_EN defined: BLINK_MASK, BLINK_PERIOD, STATUS, the counter and phase SHALL be implemented as specified.
REQ-028 Macro undefined: addresses 4-6 SHALL read 0, writes to them SHALL be ignored, no counter SHALL be synthesised, and out_port SHALL equal DATA; REQ-012..016 SHALL hold unchanged.

Verification
REQ-029 Reset with DATA_WIDTH=8, RESET_VALUE=1 -> out_port=0x01, readdata at address 0 = 0x00000001, address 5 = 0.
REQ-030 Write DATA=0xA5, then OUTSET=0x0A, then OUTCLEAR=0x81 -> DATA reads 0xA5, 0xAF, 0x2E after the respective edges.
REQ-031 BLINK_MASK=0x0F, BLINK_PERIOD=3, DATA=0x00 -> out_port alternates 0x0F/0x00 with exactly 3 cycles per level; STATUS bit0 tracks phase.
REQ-032 Mid-blink rewrite BLINK_PERIOD=3 while phase=1 -> phase=0 and out_port=DATA on the next cycle; the next toggle occurs 3 cycles later.
REQ-033 reset_n low for 1 cycle during a blink with a simultaneous DATA write of 0xFF -> DATA=0x01, mask/period=0, and out_port=0x01 is stable thereafter.
REQ-034 Build without LED_PIO_CTRL_BLINK_EN: write 0xFF to address 4 and 5 to address 5 -> both read 0, and out_port follows DATA only.
